universal_register: RTL and testbench
=====================================

# universal_register

Parametrised multi-mode register: the successor to the fixed 8-bit set/reset register. It adds configurable width, a configurable set value, and a clock-enable. It supports parallel load, logical shift, rotate, and increment/decrement, and registers a carry/shift-out flag. It is the general-purpose storage and shift element for the datapath exercises, and a drop-in replacement wherever an 8-bit set/reset register is used today.

## Interface
- WIDTH, 8, register width in bits; legal range 2..32.
- SET_VALUE, {WIDTH{1'b1}}, value loaded by the synchronous set `s`.
- clk  input  1  clock; all state updates on the rising edge.
- r  input  1  reset; asynchronous, active-high; one clock domain only.
- s  input  1  synchronous set, active-high.
- en  input  1  clock enable for mode operations, active-high.
- mode  input  3  operation select, decoded below.
- d  input  WIDTH  parallel load data.
- sil  input  1  serial input shifted into the LSB on shift-left.
- sir  input  1  serial input shifted into the MSB on shift-right.
- q  output  WIDTH  register contents.
- co  output  1  registered carry, borrow or shifted-out bit.
- z  output  1  combinational flag, 1 when q == 0.

## Operation
- Priority, highest first:
  - r: q=0, co=0, applied immediately without waiting for clk.
  - s: q=SET_VALUE, co=0; applies regardless of en.
  - en=0: hold q and co.
  - mode operation.
- Mode decode when en=1:
  - 000 hold: q and co unchanged.
  - 001 load: q=d, co=0.
  - 010 shift left: q={q[W-2:0],sil}, co=q[W-1].
  - 011 shift right: q={sir,q[W-1:1]}, co=q[0].
  - 100 rotate left: q={q[W-2:0],q[W-1]}, co=q[W-1].
  - 101 rotate right: q={q[0],q[W-1:1]}, co=q[0].
  - 110 increment: {co,q}=q+1, computed at W+1 bits; co=1 only on wrap from all-ones to 0.
  - 111 decrement: q=q-1 modulo 2^W; co=1 only on wrap from 0 to all-ones (borrow).
- Arithmetic is unsigned and wraps modulo 2^WIDTH. No saturation.
- co always reflects the most recent shift, rotate or count operation. Load, set and reset clear it. Hold and en=0 retain it.
- z is derived combinationally from q and is not registered.

## Timing
- Reset values: q=0, co=0, z=1. These are asserted asynchronously within the same delta as r rising.
- Release of r: the first edge with r=0 performs a normal operation. No extra recovery cycle.
- Latency: q and co update one clk edge after inputs are sampled. z follows q combinationally in the same cycle.
- Inputs s, en, mode, d, sil and sir are sampled only at the rising edge of clk. Glitches between edges have no effect.
- Reset mid-operation: r asserted between edges forces q=0 immediately. r asserted coincident with an edge wins over any sampled operation.
- Simultaneous s and any mode: s wins, q=SET_VALUE, co=0.
- Simultaneous r and s: r wins, q=0.
- No multi-cycle operations and no internal state beyond q and co.

## Test plan
(WIDTH=8, SET_VALUE=8'hFF unless noted)
- **Reset:** load 8'h5A, then pulse r between edges.
  - q=8'h00, co=0, z=1 before the next clk edge.
  - Hold r across an edge with s=1 and mode=001: q stays 8'h00.
- **Load and shift:**
  - Load 8'h11, then shift left with sil=1 → q=8'h23, co=0.
  - Load 8'h81, then shift right with sir=0 → q=8'h40, co=1.
  - A further shift right with sir=1 → q=8'hA0, co=0.
- **Rotate:**
  - Load 8'h81, rotate left → q=8'h03, co=1.
  - Rotate right twice → q=8'h81 then 8'hC0, with co=1 then co=1.
- **Count wrap:**
  - Load 8'hFE, increment twice → 8'hFF with co=0, then 8'h00 with co=1, z=1.
  - Decrement once → q=8'hFF, co=1.
  - Decrement again → q=8'hFE, co=0.
- **Priority and enable:**
  - With q=8'h33, set en=0 and mode=001, d=8'h00 → q holds 8'h33.
  - Set s=1 with en=0 → q=8'hFF, co=0.
  - Set s=1 with mode=110 → q=8'hFF, not an increment.
- **Parameter sweep:**
  - WIDTH=4, SET_VALUE=4'hA: s → q=4'hA.
  - Increment from 4'hF → 4'h0, co=1.
  - Repeat the increment check at WIDTH=16 from 16'hFFFF → 16'h0000, co=1.

Source files
------------

// File: rtl/universal_register.sv
// Parametrised multi-mode register: parallel load, shift, rotate and up/down
// count, with a registered carry/shift-out flag and a combinational zero flag.
module universal_register #(
  parameter int              WIDTH     = 8,
  parameter logic [WIDTH-1:0] SET_VALUE = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             r,
  input  logic             s,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sil,
  input  logic             sir,
  output logic [WIDTH-1:0] q,
  output logic             co,
  output logic             z
);

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;
  localparam logic [2:0] MODE_INC  = 3'b110;
  localparam logic [2:0] MODE_DEC  = 3'b111;

  logic [WIDTH-1:0] q_next;
  logic             co_next;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;

  // Counting is done one bit wider so the top bit is the carry or borrow.
  assign sum  = {1'b0, q} + {{WIDTH{1'b0}}, 1'b1};
  assign diff = {1'b0, q} - {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    q_next  = q;
    co_next = co;
    if (s) begin
      q_next  = SET_VALUE;
      co_next = 1'b0;
    end else if (en) begin
      case (mode)
        MODE_HOLD: begin
          q_next  = q;
          co_next = co;
        end
        MODE_LOAD: begin
          q_next  = d;
          co_next = 1'b0;
        end
        MODE_SHL: begin
          q_next  = {q[WIDTH-2:0], sil};
          co_next = q[WIDTH-1];
        end
        MODE_SHR: begin
          q_next  = {sir, q[WIDTH-1:1]};
          co_next = q[0];
        end
        MODE_ROL: begin
          q_next  = {q[WIDTH-2:0], q[WIDTH-1]};
          co_next = q[WIDTH-1];
        end
        MODE_ROR: begin
          q_next  = {q[0], q[WIDTH-1:1]};
          co_next = q[0];
        end
        MODE_INC: begin
          q_next  = sum[WIDTH-1:0];
          co_next = sum[WIDTH];
        end
        MODE_DEC: begin
          q_next  = diff[WIDTH-1:0];
          co_next = diff[WIDTH];
        end
        default: begin
          q_next  = q;
          co_next = co;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      q  <= '0;
      co <= 1'b0;
    end else begin
      q  <= q_next;
      co <= co_next;
    end
  end

  assign z = (q == '0);

endmodule

// File: tb/tb_universal_register.sv
// Directed bench for universal_register at WIDTH=8, WIDTH=4 (SET_VALUE=4'hA)
// and WIDTH=16, driving all three instances from shared controls.
module tb_universal_register;

  logic        clk;
  logic        r;
  logic        s;
  logic        en;
  logic [2:0]  mode;
  logic        sil;
  logic        sir;
  logic [7:0]  d8;
  logic [3:0]  d4;
  logic [15:0] d16;
  logic [7:0]  q8;
  logic [3:0]  q4;
  logic [15:0] q16;
  logic        co8, co4, co16;
  logic        z8, z4, z16;

  int checks;
  int failures;

  universal_register #(.WIDTH(8)) dut8 (
    .clk(clk), .r(r), .s(s), .en(en), .mode(mode), .d(d8),
    .sil(sil), .sir(sir), .q(q8), .co(co8), .z(z8)
  );

  universal_register #(.WIDTH(4), .SET_VALUE(4'hA)) dut4 (
    .clk(clk), .r(r), .s(s), .en(en), .mode(mode), .d(d4),
    .sil(sil), .sir(sir), .q(q4), .co(co4), .z(z4)
  );

  universal_register #(.WIDTH(16)) dut16 (
    .clk(clk), .r(r), .s(s), .en(en), .mode(mode), .d(d16),
    .sil(sil), .sir(sir), .q(q16), .co(co16), .z(z16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive on the falling edge, then sample just after the rising edge.
  task automatic step(input logic s_i, input logic en_i, input logic [2:0] mode_i,
                      input logic [31:0] d_i, input logic sil_i, input logic sir_i);
    @(negedge clk);
    s    = s_i;
    en   = en_i;
    mode = mode_i;
    d8   = d_i[7:0];
    d4   = d_i[3:0];
    d16  = d_i[15:0];
    sil  = sil_i;
    sir  = sir_i;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    r    = 1'b1;
    s    = 1'b0;
    en   = 1'b0;
    mode = 3'b000;
    sil  = 1'b0;
    sir  = 1'b0;
    d8   = '0;
    d4   = '0;
    d16  = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_q", {24'h0, q8}, 32'h00);
    chk("rst_co", {31'h0, co8}, 32'h0);
    chk("rst_z", {31'h0, z8}, 32'h1);
    @(negedge clk);
    r = 1'b0;

    // Asynchronous reset between edges
    step(1'b0, 1'b1, 3'b001, 32'h5A, 1'b0, 1'b0);
    chk("load_5a", {24'h0, q8}, 32'h5A);
    chk("load_5a_z", {31'h0, z8}, 32'h0);
    #2 r = 1'b1;
    #1;
    chk("async_rst_q", {24'h0, q8}, 32'h00);
    chk("async_rst_co", {31'h0, co8}, 32'h0);
    chk("async_rst_z", {31'h0, z8}, 32'h1);
    step(1'b1, 1'b1, 3'b001, 32'h5A, 1'b0, 1'b0);
    chk("rst_beats_set_q", {24'h0, q8}, 32'h00);
    chk("rst_beats_set_co", {31'h0, co8}, 32'h0);
    @(negedge clk);
    r = 1'b0;

    // Load and shift
    step(1'b0, 1'b1, 3'b001, 32'h11, 1'b0, 1'b0);
    chk("load_11", {24'h0, q8}, 32'h11);
    step(1'b0, 1'b1, 3'b010, 32'h00, 1'b1, 1'b0);
    chk("shl_q", {24'h0, q8}, 32'h23);
    chk("shl_co", {31'h0, co8}, 32'h0);
    step(1'b0, 1'b1, 3'b001, 32'h81, 1'b0, 1'b0);
    step(1'b0, 1'b1, 3'b011, 32'h00, 1'b0, 1'b0);
    chk("shr0_q", {24'h0, q8}, 32'h40);
    chk("shr0_co", {31'h0, co8}, 32'h1);
    step(1'b0, 1'b1, 3'b011, 32'h00, 1'b0, 1'b1);
    chk("shr1_q", {24'h0, q8}, 32'hA0);
    chk("shr1_co", {31'h0, co8}, 32'h0);

    // Rotate
    step(1'b0, 1'b1, 3'b001, 32'h81, 1'b0, 1'b0);
    step(1'b0, 1'b1, 3'b100, 32'h00, 1'b0, 1'b0);
    chk("rol_q", {24'h0, q8}, 32'h03);
    chk("rol_co", {31'h0, co8}, 32'h1);
    step(1'b0, 1'b1, 3'b101, 32'h00, 1'b0, 1'b0);
    chk("ror1_q", {24'h0, q8}, 32'h81);
    chk("ror1_co", {31'h0, co8}, 32'h1);
    step(1'b0, 1'b1, 3'b101, 32'h00, 1'b0, 1'b0);
    chk("ror2_q", {24'h0, q8}, 32'hC0);
    chk("ror2_co", {31'h0, co8}, 32'h1);
    step(1'b0, 1'b1, 3'b000, 32'h00, 1'b0, 1'b0);
    chk("hold_q", {24'h0, q8}, 32'hC0);
    chk("hold_co", {31'h0, co8}, 32'h1);

    // Count wrap
    step(1'b0, 1'b1, 3'b001, 32'hFE, 1'b0, 1'b0);
    step(1'b0, 1'b1, 3'b110, 32'h00, 1'b0, 1'b0);
    chk("inc1_q", {24'h0, q8}, 32'hFF);
    chk("inc1_co", {31'h0, co8}, 32'h0);
    step(1'b0, 1'b1, 3'b110, 32'h00, 1'b0, 1'b0);
    chk("inc2_q", {24'h0, q8}, 32'h00);
    chk("inc2_co", {31'h0, co8}, 32'h1);
    chk("inc2_z", {31'h0, z8}, 32'h1);
    step(1'b0, 1'b1, 3'b111, 32'h00, 1'b0, 1'b0);
    chk("dec1_q", {24'h0, q8}, 32'hFF);
    chk("dec1_co", {31'h0, co8}, 32'h1);
    step(1'b0, 1'b0, 3'b001, 32'h00, 1'b0, 1'b0);
    chk("en0_keep_q", {24'h0, q8}, 32'hFF);
    chk("en0_keep_co", {31'h0, co8}, 32'h1);
    step(1'b0, 1'b1, 3'b111, 32'h00, 1'b0, 1'b0);
    chk("dec2_q", {24'h0, q8}, 32'hFE);
    chk("dec2_co", {31'h0, co8}, 32'h0);

    // Priority and enable
    step(1'b0, 1'b1, 3'b001, 32'h33, 1'b0, 1'b0);
    step(1'b0, 1'b0, 3'b001, 32'h00, 1'b0, 1'b0);
    chk("en0_hold_q", {24'h0, q8}, 32'h33);
    step(1'b1, 1'b0, 3'b001, 32'h00, 1'b0, 1'b0);
    chk("set_en0_q", {24'h0, q8}, 32'hFF);
    chk("set_en0_co", {31'h0, co8}, 32'h0);
    step(1'b0, 1'b1, 3'b001, 32'h12, 1'b0, 1'b0);
    step(1'b0, 1'b1, 3'b110, 32'h00, 1'b0, 1'b0);
    chk("inc_13", {24'h0, q8}, 32'h13);
    step(1'b1, 1'b1, 3'b110, 32'h00, 1'b0, 1'b0);
    chk("set_over_inc_q", {24'h0, q8}, 32'hFF);
    chk("set_over_inc_co", {31'h0, co8}, 32'h0);

    // Parameter sweep: WIDTH=4 and WIDTH=16 instances
    step(1'b0, 1'b1, 3'b001, 32'hFFFF, 1'b0, 1'b0);
    chk("w4_load", {28'h0, q4}, 32'hF);
    chk("w16_load", {16'h0, q16}, 32'hFFFF);
    step(1'b0, 1'b1, 3'b110, 32'h0, 1'b0, 1'b0);
    chk("w4_inc_q", {28'h0, q4}, 32'h0);
    chk("w4_inc_co", {31'h0, co4}, 32'h1);
    chk("w4_inc_z", {31'h0, z4}, 32'h1);
    chk("w16_inc_q", {16'h0, q16}, 32'h0000);
    chk("w16_inc_co", {31'h0, co16}, 32'h1);
    step(1'b1, 1'b1, 3'b000, 32'h0, 1'b0, 1'b0);
    chk("w4_set", {28'h0, q4}, 32'hA);
    chk("w4_set_co", {31'h0, co4}, 32'h0);
    chk("w16_set", {16'h0, q16}, 32'hFFFF);
    step(1'b0, 1'b1, 3'b010, 32'h0, 1'b0, 1'b0);
    chk("w4_shl_q", {28'h0, q4}, 32'h4);
    chk("w4_shl_co", {31'h0, co4}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
